// File: rtl/axis_eth_tx_pad_if.sv
// Byte-wide AXI-Stream bundle used on both sides of axis_eth_tx_pad.
interface axis_eth_tx_pad_if #(
  parameter int USER_WIDTH = 1
);
  logic [7:0]            tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_eth_tx_pad.sv
// Ethernet TX pad stage: zero-pads short frames to MIN_FRAME_LEN and reports frame lengths.
// Define AXIS_ETH_TX_PAD_TRUNCATE_EN to truncate frames at MAX_FRAME_LEN and drop the tail.
module axis_eth_tx_pad #(
  parameter int MIN_FRAME_LEN = 60,
  parameter int MAX_FRAME_LEN = 1514,
  parameter int USER_WIDTH    = 1
) (
  input  logic                clk,
  input  logic                rst,
  axis_eth_tx_pad_if.slave    s_axis,
  axis_eth_tx_pad_if.master   m_axis,
  output logic [15:0]         status_frame_len,
  output logic                status_frame_done,
  output logic                status_oversize
);

  typedef enum logic [1:0] {
    ST_PASS,
    ST_PAD
`ifdef AXIS_ETH_TX_PAD_TRUNCATE_EN
    , ST_DROP
`endif
  } state_t;

  state_t                r_state;
  logic [15:0]           r_cnt;
  logic [USER_WIDTH-1:0] r_pad_user;
  logic [7:0]            r_tdata;
  logic                  r_tvalid;
  logic                  r_tlast;
  logic [USER_WIDTH-1:0] r_tuser;

  logic                  w_load_en;
  logic                  w_s_tready;
  logic                  w_accept;
  logic [16:0]           w_cnt_p1;
  logic [15:0]           w_cnt_sat;
  logic                  w_min_hit;
  logic                  w_pad_done;
  logic                  w_max_hit;

  assign m_axis.tdata  = r_tdata;
  assign m_axis.tvalid = r_tvalid;
  assign m_axis.tlast  = r_tlast;
  assign m_axis.tuser  = r_tuser;

  assign w_load_en  = !r_tvalid || m_axis.tready;
  assign w_accept   = s_axis.tvalid && w_s_tready;
  assign w_cnt_p1   = {1'b0, r_cnt} + 17'd1;
  assign w_cnt_sat  = (r_cnt == 16'hFFFF) ? r_cnt : w_cnt_p1[15:0];
  assign w_min_hit  = (w_cnt_p1 >= 17'(MIN_FRAME_LEN));
  assign w_pad_done = (w_cnt_p1 == 17'(MIN_FRAME_LEN));
  // Once cnt saturates, cnt+1 exceeds 16 bits, so the oversize pulse cannot repeat.
  assign w_max_hit  = (w_cnt_p1 == 17'(MAX_FRAME_LEN));

`ifdef AXIS_ETH_TX_PAD_TRUNCATE_EN
  logic [USER_WIDTH-1:0] w_user_bad;
  always_comb begin
    w_user_bad    = s_axis.tuser;
    w_user_bad[0] = 1'b1;
  end
`endif

  always_comb begin
    w_s_tready = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_PASS: w_s_tready = w_load_en;
`ifdef AXIS_ETH_TX_PAD_TRUNCATE_EN
        ST_DROP: w_s_tready = 1'b1;
`endif
        default: w_s_tready = 1'b0;
      endcase
    end
  end

  assign s_axis.tready = w_s_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= ST_PASS;
      r_cnt             <= '0;
      r_pad_user        <= '0;
      r_tdata           <= '0;
      r_tvalid          <= 1'b0;
      r_tlast           <= 1'b0;
      r_tuser           <= '0;
      status_frame_len  <= '0;
      status_frame_done <= 1'b0;
      status_oversize   <= 1'b0;
    end else begin
      status_frame_done <= 1'b0;
      status_oversize   <= 1'b0;
      case (r_state)
        ST_PASS: begin
          if (w_load_en) begin
            r_tvalid <= w_accept;
            if (w_accept) begin
              r_tdata <= s_axis.tdata;
              r_tuser <= s_axis.tuser;
              r_tlast <= 1'b0;
              r_cnt   <= w_cnt_sat;
              if (s_axis.tlast) begin
                if (w_min_hit) begin
                  r_tlast           <= 1'b1;
                  r_cnt             <= '0;
                  status_frame_done <= 1'b1;
                  status_frame_len  <= w_cnt_sat;
                end else begin
                  r_pad_user <= s_axis.tuser;
                  r_state    <= ST_PAD;
                end
              end else if (w_max_hit) begin
                status_oversize <= 1'b1;
`ifdef AXIS_ETH_TX_PAD_TRUNCATE_EN
                r_tlast           <= 1'b1;
                r_tuser           <= w_user_bad;
                r_cnt             <= '0;
                status_frame_done <= 1'b1;
                status_frame_len  <= 16'(MAX_FRAME_LEN);
                r_state           <= ST_DROP;
`endif
              end
            end
          end
        end
        ST_PAD: begin
          if (w_load_en) begin
            r_tvalid <= 1'b1;
            r_tdata  <= '0;
            r_tuser  <= r_pad_user;
            r_tlast  <= 1'b0;
            r_cnt    <= w_cnt_sat;
            if (w_pad_done) begin
              r_tlast           <= 1'b1;
              r_cnt             <= '0;
              status_frame_done <= 1'b1;
              status_frame_len  <= w_cnt_sat;
              r_state           <= ST_PASS;
            end
          end
        end
`ifdef AXIS_ETH_TX_PAD_TRUNCATE_EN
        ST_DROP: begin
          if (w_load_en) r_tvalid <= 1'b0;
          if (w_accept && s_axis.tlast) r_state <= ST_PASS;
        end
`endif
        default: r_state <= ST_PASS;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_eth_tx_pad.sv
// Directed bench for axis_eth_tx_pad: padding, back-to-back, backpressure, oversize, reset mid-pad.
module tb_axis_eth_tx_pad;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] status_frame_len;
  logic        status_frame_done;
  logic        status_oversize;

  axis_eth_tx_pad_if #(.USER_WIDTH(1)) s_if ();
  axis_eth_tx_pad_if #(.USER_WIDTH(1)) m_if ();

  axis_eth_tx_pad #(
    .MIN_FRAME_LEN(60),
    .MAX_FRAME_LEN(1514),
    .USER_WIDTH(1)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .s_axis            (s_if),
    .m_axis            (m_if),
    .status_frame_len  (status_frame_len),
    .status_frame_done (status_frame_done),
    .status_oversize   (status_oversize)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  d;
    logic        l;
    logic [0:0]  u;
    int unsigned cyc;
  } beat_t;

  beat_t       out_q[$];
  int          len_q[$];
  int          checks = 0;
  int          errors = 0;
  int          oversize_cnt = 0;
  int          ready_low = 0;
  int          stall_viol = 0;
  int          stall_seen = 0;
  int unsigned cyc = 0;
  int          rdy_mode = 0;

  // Downstream ready: held high, or pseudo-random from an LFSR.
  logic [15:0] lfsr = 16'hACE1;
  always @(posedge clk) begin
    #1;
    lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    m_if.tready = (rdy_mode == 0) ? 1'b1 : lfsr[0];
  end

  logic       p_stall = 1'b0;
  logic [7:0] p_d;
  logic       p_l;
  logic [0:0] p_u;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      p_stall = 1'b0;
    end else begin
      if (p_stall && (m_if.tvalid !== 1'b1 || m_if.tdata !== p_d ||
                      m_if.tlast !== p_l || m_if.tuser !== p_u))
        stall_viol++;
      if (m_if.tvalid && m_if.tready)
        out_q.push_back('{m_if.tdata, m_if.tlast, m_if.tuser, cyc});
      if (m_if.tvalid && !m_if.tready) stall_seen++;
      p_stall = m_if.tvalid && !m_if.tready;
      p_d = m_if.tdata;
      p_l = m_if.tlast;
      p_u = m_if.tuser;
      if (status_frame_done) len_q.push_back(int'(status_frame_len));
      if (status_oversize) oversize_cnt++;
      if (!s_if.tready) ready_low++;
    end
  end

  task automatic send_frame(input int n, input logic [7:0] start, input logic u);
    logic acc;
    int   waited;
    for (int i = 0; i < n; i++) begin
      s_if.tdata  = 8'(int'(start) + i);
      s_if.tvalid = 1'b1;
      s_if.tlast  = (i == n - 1);
      s_if.tuser  = u;
      waited = 0;
      acc = 1'b0;
      while (!acc && waited < 2000) begin
        @(negedge clk);
        acc = s_if.tready;
        @(posedge clk);
        #1;
        waited++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL send_timeout beat %0d not accepted, required accept within 2000 cycles", i);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        return;
      end
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    while (len_q.size() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (len_q.size() < target) begin
      errors++;
      $display("FAIL %s_done_timeout got %0d frames, required %0d", name, len_q.size(), target);
    end
  endtask

  task automatic test_reset();
    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (s_if.tready !== 1'b0) begin errors++; $display("FAIL rst_s_tready got %b required 0", s_if.tready); end
    checks++;
    if (m_if.tvalid !== 1'b0 || m_if.tdata !== 8'h00 || m_if.tlast !== 1'b0 || m_if.tuser !== 1'b0) begin
      errors++;
      $display("FAIL rst_m_axis got v%b d%h l%b u%b required v0 d00 l0 u0",
               m_if.tvalid, m_if.tdata, m_if.tlast, m_if.tuser);
    end
    checks++;
    if (status_frame_len !== 16'd0 || status_frame_done !== 1'b0 || status_oversize !== 1'b0) begin
      errors++;
      $display("FAIL rst_status got len%0d done%b ovf%b required 0 0 0",
               status_frame_len, status_frame_done, status_oversize);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_short_frame();
    int ob = out_q.size();
    int lb = len_q.size();
    int rl = ready_low;
    int n;
    send_frame(10, 8'h01, 1'b0);
    wait_done(lb + 1, 200, "short");
    n = out_q.size() - ob;
    checks++;
    if (n !== 60) begin errors++; $display("FAIL short_count got %0d required 60", n); end
    for (int i = 0; i < n && i < 60; i++) begin
      logic [7:0] ed = (i < 10) ? 8'(i + 1) : 8'h00;
      checks++;
      if (out_q[ob+i].d !== ed || out_q[ob+i].l !== (i == 59) || out_q[ob+i].u !== 1'b0) begin
        errors++;
        $display("FAIL short_beat%0d got d%h l%b u%b required d%h l%b u0",
                 i, out_q[ob+i].d, out_q[ob+i].l, out_q[ob+i].u, ed, (i == 59));
      end
    end
    checks++;
    if (len_q.size() > lb && len_q[lb] !== 60) begin errors++; $display("FAIL short_len got %0d required 60", len_q[lb]); end
    checks++;
    if (ready_low - rl !== 50) begin errors++; $display("FAIL short_ready_low got %0d required 50", ready_low - rl); end
  endtask

  task automatic test_user_pad();
    int ob = out_q.size();
    int lb = len_q.size();
    int n;
    send_frame(1, 8'hA5, 1'b1);
    wait_done(lb + 1, 200, "user");
    n = out_q.size() - ob;
    checks++;
    if (n !== 60) begin errors++; $display("FAIL user_count got %0d required 60", n); end
    for (int i = 0; i < n && i < 60; i++) begin
      logic [7:0] ed = (i == 0) ? 8'hA5 : 8'h00;
      checks++;
      if (out_q[ob+i].d !== ed || out_q[ob+i].l !== (i == 59) || out_q[ob+i].u !== 1'b1) begin
        errors++;
        $display("FAIL user_beat%0d got d%h l%b u%b required d%h l%b u1",
                 i, out_q[ob+i].d, out_q[ob+i].l, out_q[ob+i].u, ed, (i == 59));
      end
    end
    checks++;
    if (len_q.size() > lb && len_q[lb] !== 60) begin errors++; $display("FAIL user_len got %0d required 60", len_q[lb]); end
  endtask

  task automatic test_back_to_back();
    int ob = out_q.size();
    int lb = len_q.size();
    int n;
    send_frame(60, 8'h10, 1'b0);
    send_frame(64, 8'h80, 1'b0);
    wait_done(lb + 2, 300, "b2b");
    n = out_q.size() - ob;
    checks++;
    if (n !== 124) begin errors++; $display("FAIL b2b_count got %0d required 124", n); end
    for (int i = 0; i < n && i < 124; i++) begin
      logic [7:0] ed = (i < 60) ? 8'(16 + i) : 8'(128 + i - 60);
      logic       el = (i == 59) || (i == 123);
      checks++;
      if (out_q[ob+i].d !== ed || out_q[ob+i].l !== el ||
          out_q[ob+i].cyc !== out_q[ob].cyc + i) begin
        errors++;
        $display("FAIL b2b_beat%0d got d%h l%b cyc+%0d required d%h l%b cyc+%0d",
                 i, out_q[ob+i].d, out_q[ob+i].l, out_q[ob+i].cyc - out_q[ob].cyc, ed, el, i);
      end
    end
    checks++;
    if (len_q.size() >= lb + 2 && (len_q[lb] !== 60 || len_q[lb+1] !== 64)) begin
      errors++;
      $display("FAIL b2b_len got %0d,%0d required 60,64", len_q[lb], len_q[lb+1]);
    end
  endtask

  task automatic test_backpressure();
    int ob = out_q.size();
    int lb = len_q.size();
    int sv = stall_viol;
    int ss = stall_seen;
    int n;
    rdy_mode = 1;
    send_frame(5, 8'h30, 1'b0);
    wait_done(lb + 1, 2000, "bp");
    rdy_mode = 0;
    @(posedge clk);
    #1;
    n = out_q.size() - ob;
    checks++;
    if (n !== 60) begin errors++; $display("FAIL bp_count got %0d required 60", n); end
    for (int i = 0; i < n && i < 60; i++) begin
      logic [7:0] ed = (i < 5) ? 8'(48 + i) : 8'h00;
      checks++;
      if (out_q[ob+i].d !== ed || out_q[ob+i].l !== (i == 59)) begin
        errors++;
        $display("FAIL bp_beat%0d got d%h l%b required d%h l%b",
                 i, out_q[ob+i].d, out_q[ob+i].l, ed, (i == 59));
      end
    end
    checks++;
    if (stall_viol - sv !== 0) begin errors++; $display("FAIL bp_stable got %0d changes required 0", stall_viol - sv); end
    checks++;
    if (stall_seen - ss <= 0) begin errors++; $display("FAIL bp_stalls got %0d stalls required >0", stall_seen - ss); end
    checks++;
    if (len_q.size() > lb && len_q[lb] !== 60) begin errors++; $display("FAIL bp_len got %0d required 60", len_q[lb]); end
  endtask

  task automatic test_oversize();
    int ob = out_q.size();
    int lb = len_q.size();
    int oc = oversize_cnt;
    int n;
`ifdef AXIS_ETH_TX_PAD_TRUNCATE_EN
    int exp_n = 1514;
`else
    int exp_n = 1600;
`endif
    send_frame(1600, 8'h00, 1'b0);
    wait_done(lb + 1, 3000, "ovs");
    repeat (5) @(posedge clk);
    #1;
    n = out_q.size() - ob;
    checks++;
    if (n !== exp_n) begin errors++; $display("FAIL ovs_count got %0d required %0d", n, exp_n); end
    for (int i = 0; i < n && i < exp_n; i++) begin
      logic       el = (i == exp_n - 1);
`ifdef AXIS_ETH_TX_PAD_TRUNCATE_EN
      logic [0:0] eu = (i == exp_n - 1);
`else
      logic [0:0] eu = 1'b0;
`endif
      checks++;
      if (out_q[ob+i].d !== 8'(i) || out_q[ob+i].l !== el || out_q[ob+i].u !== eu) begin
        errors++;
        $display("FAIL ovs_beat%0d got d%h l%b u%b required d%h l%b u%b",
                 i, out_q[ob+i].d, out_q[ob+i].l, out_q[ob+i].u, 8'(i), el, eu);
      end
    end
    checks++;
    if (len_q.size() !== lb + 1) begin errors++; $display("FAIL ovs_done_count got %0d required 1", len_q.size() - lb); end
    checks++;
    if (len_q.size() > lb && len_q[lb] !== exp_n) begin errors++; $display("FAIL ovs_len got %0d required %0d", len_q[lb], exp_n); end
    checks++;
    if (oversize_cnt - oc !== 1) begin errors++; $display("FAIL ovs_pulse got %0d required 1", oversize_cnt - oc); end
    @(negedge clk);
    checks++;
    if (s_if.tready !== 1'b1) begin errors++; $display("FAIL ovs_ready_after got %b required 1", s_if.tready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_pad();
    int ob;
    int lb;
    int n;
    send_frame(3, 8'h55, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL rstpad_tvalid got %b required 0", m_if.tvalid); end
    checks++;
    if (s_if.tready !== 1'b1) begin errors++; $display("FAIL rstpad_state_ready got %b required 1", s_if.tready); end
    checks++;
    if (dut.r_cnt !== 16'd0) begin errors++; $display("FAIL rstpad_cnt got %0d required 0", dut.r_cnt); end
    @(posedge clk);
    #1;
    ob = out_q.size();
    lb = len_q.size();
    send_frame(60, 8'h40, 1'b0);
    wait_done(lb + 1, 200, "rstpad");
    n = out_q.size() - ob;
    checks++;
    if (n !== 60) begin errors++; $display("FAIL rstpad_count got %0d required 60", n); end
    for (int i = 0; i < n && i < 60; i++) begin
      checks++;
      if (out_q[ob+i].d !== 8'(64 + i) || out_q[ob+i].l !== (i == 59)) begin
        errors++;
        $display("FAIL rstpad_beat%0d got d%h l%b required d%h l%b",
                 i, out_q[ob+i].d, out_q[ob+i].l, 8'(64 + i), (i == 59));
      end
    end
    checks++;
    if (len_q.size() !== lb + 1 || len_q[lb] !== 60) begin
      errors++;
      $display("FAIL rstpad_len got %0d frames len %0d required 1 frame len 60",
               len_q.size() - lb, (len_q.size() > lb) ? len_q[lb] : -1);
    end
  endtask

  initial begin
    test_reset();
    test_short_frame();
    test_user_pad();
    test_back_to_back();
    test_backpressure();
    test_oversize();
    test_reset_mid_pad();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_eth_tx_pad.md
# axis_eth_tx_pad

Byte-wide AXI-Stream stage between the Ethernet TX frame FIFO output and the MAC transmit input. It enforces the Ethernet minimum frame length (excluding FCS) by appending zero bytes to short frames, and it reports the length of every frame sent. Optionally, it truncates oversize frames and marks them bad. Throughput is one byte per cycle when not padding, through one registered output stage.

## Interface
- MIN_FRAME_LEN, 60: minimum output frame length in bytes; must be ≥1.
- MAX_FRAME_LEN, 1514: oversize threshold in bytes; must be > MIN_FRAME_LEN and < 65536.
- USER_WIDTH, 1: tuser width; bit 0 is the bad-frame flag.

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_axis_tdata  in  8  input byte
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  input end of frame
- s_axis_tuser  in  USER_WIDTH  input sideband
- m_axis_tdata  out  8  output byte
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  output end of frame
- m_axis_tuser  out  USER_WIDTH  output sideband
- status_frame_len  out  16  byte count of the last completed output frame, including pad
- status_frame_done  out  1  one-cycle pulse; status_frame_len is valid
- status_oversize  out  1  one-cycle pulse; a frame reached MAX_FRAME_LEN bytes without tlast

## Operation
- The output is a single register: m_axis_* is loaded when it is empty or when it is being accepted (load_en = !m_axis_tvalid || m_axis_tready).
- cnt is a 16-bit count of bytes loaded in the current frame. It resets to 0 after each output tlast.
- The state machine has three states:
  - PASS: s_axis_tready = load_en.
  - PAD: s_axis_tready = 0.
  - DROP: s_axis_tready = 1; nothing is output.
- PASS behaviour, for each accepted byte:
  - The byte is copied to the output with the same tuser.
  - If tlast=1 and cnt+1 ≥ MIN_FRAME_LEN: the output tlast is 1 and cnt is cleared.
  - If tlast=1 and cnt+1 < MIN_FRAME_LEN: the output tlast is 0, s_axis_tuser is captured to pad_user, and the state moves to PAD.
  - If tlast=0 and cnt+1 == MAX_FRAME_LEN: status_oversize pulses. The truncation response is in Configuration.
- PAD behaviour, on each load_en:
  - Load tdata=0 with tuser=pad_user.
  - When cnt+1 == MIN_FRAME_LEN: tlast=1, cnt is cleared, and the state returns to PASS.
- DROP: input bytes are discarded until an accepted tlast, then the state returns to PASS. No status_frame_done is generated for the discarded tail.
- Status: status_frame_done pulses, and status_frame_len updates, the cycle after any output byte with tlast=1 is loaded.
- cnt saturates at 16'hFFFF.
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser=0, s_axis_tready=0 during rst, status_frame_len=0, status_frame_done=0, status_oversize=0, state=PASS, cnt=0.
- Reset mid-frame discards everything, including any held output byte. Upstream and downstream share rst, so they drop their partial frames too.

## Timing
- Latency from input accept to m_axis_tvalid is 1 cycle.
- Sustained rate is 1 byte/cycle in PASS with m_axis_tready held high.
- PAD emits 1 byte/cycle while m_axis_tready is high.
- s_axis_tready is combinational from m_axis_tready and state. There is no combinational path from s_axis_tvalid to m_axis_*.
- Backpressure: m_axis_tready=0 with m_axis_tvalid=1 holds all m_axis_* stable and deasserts s_axis_tready, in both PASS and PAD.
- A frame of exactly MIN_FRAME_LEN bytes passes with no pad and no stall.
- After a short frame's last input byte, the next frame's first byte is accepted on the cycle after the final pad byte is loaded.

## Configuration
- AXIS_ETH_TX_PAD_TRUNCATE_EN defined: when byte number MAX_FRAME_LEN is accepted without tlast, that byte is output with tlast=1 and tuser[0]=1, status_frame_done pulses with len=MAX_FRAME_LEN, and the state moves to DROP.
  - If that byte itself has tlast=1, the frame is normal and no truncation occurs.
- Undefined: the DROP state is not built, and oversize frames pass through unchanged. status_oversize still pulses; cnt keeps counting and saturates.

## Test plan
- 10-byte frame 0x01..0x0A, tuser=0, m_axis_tready=1:
  - Output is 0x01..0x0A then 50 bytes of 0x00; tlast only on byte 60; tuser=0 throughout.
  - status_frame_len=60.
  - s_axis_tready is low for the 50 pad cycles.
- 1-byte frame with tuser=1 -> 60 output bytes, all with tuser=1, tlast on byte 60.
- Back-to-back 60-byte and 64-byte frames, m_axis_tready=1:
  - No bubbles and no padding.
  - status_frame_done pulses with lengths 60 then 64.
- m_axis_tready toggled pseudo-randomly during a 5-byte frame -> the output byte sequence is identical to the steady case, and outputs are stable while stalled.
- 1600-byte frame:
  - With TRUNCATE_EN: output is 1514 bytes, byte 1514 has tlast=1 and tuser[0]=1, the remaining 86 input bytes are consumed with tready=1 and not output, and status_oversize pulses once.
  - Without TRUNCATE_EN: all 1600 bytes pass, and status_frame_len=1600.
- rst asserted during the pad of a 3-byte frame:
  - Next cycle: m_axis_tvalid=0, state is PASS, cnt=0.
  - A following 60-byte frame passes unmodified.
